// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction-memory read port, redirect request and
// the decode-facing valid/ready handshake.
//   master : the fetch stage (drives imem_addr/imem_read_not_write and the
//            instr_* outputs; samples imem_data, redirect_*, instr_ready)
//   slave  : the environment (memory + decode + branch unit)
interface instr_fetch_if #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 36
);
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_read_not_write;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_target;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_word;
  logic [ADDR_WIDTH-1:0]  instr_pc;

  modport master (
    output imem_addr, imem_read_not_write, instr_valid, instr_word, instr_pc,
    input  imem_data, redirect_valid, redirect_target, instr_ready
  );
  modport slave (
    input  imem_addr, imem_read_not_write, instr_valid, instr_word, instr_pc,
    output imem_data, redirect_valid, redirect_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program counter owner in front of a synchronous instruction
// RAM. Issues at most one read per cycle, buffers returned words with their PC
// in a 2-entry queue and hands them to decode over valid/ready. A redirect
// flushes everything fetched but not yet consumed.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : instr_fetch_if.master (imem read port, redirect, decode handshake)
//   fetch_count, stall_count : 32-bit statistics, only with IFETCH_STATS_EN
// Optional feature macro: IFETCH_STATS_EN
module instr_fetch #(
  parameter int                    ADDR_WIDTH  = 24,
  parameter int                    INSTR_WIDTH = 36,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_if.master      bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] word;
  } entry_t;

  state_t                state, state_nxt;
  entry_t [1:0]          q;          // q[0] is the head
  logic   [1:0]          occ, occ_after;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] addr_q;     // last issued address == PC of the in-flight read
  logic                  pop, push, issue, redir, vld;

  assign vld       = (occ != 2'd0);
  assign pop       = vld & bus.instr_ready;
  // A redirect throws away any response landing this cycle.
  assign push      = inflight & ~redir;
  assign occ_after = occ - {1'b0, pop};

  // The registered state trails the redirect by one cycle; the redirect cycle
  // itself is recognised from redirect_valid so the target can issue the very
  // next cycle.
  always_comb begin
    state_nxt = state;
    redir     = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN, REDIR: begin
        if (bus.redirect_valid) begin
          redir     = 1'b1;
          state_nxt = REDIR;
        end else begin
          state_nxt = RUN;
          // Never let queued + outstanding exceed the 2 queue slots.
          issue = ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      q        <= '0;
    end else begin
      inflight <= issue;
      if (redir)      fetch_pc <= bus.redirect_target;
      else if (issue) fetch_pc <= fetch_pc + 1'b1;
      if (issue)      addr_q   <= fetch_pc;

      // Shift on pop, then write the new entry into the first free slot; when
      // the queue drains to empty the push lands in the head slot.
      if (pop)  q[0] <= q[1];
      if (push) q[occ_after[0]] <= '{pc: addr_q, word: bus.imem_data};

      if (redir) occ <= 2'd0;
      else       occ <= occ_after + {1'b0, push};
    end
  end

  assign bus.imem_addr           = issue ? fetch_pc : addr_q;
  assign bus.imem_read_not_write = 1'b1;
  assign bus.instr_valid         = vld;
  assign bus.instr_word          = q[0].word;
  assign bus.instr_pc            = q[0].pc;

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop) fetch_count <= fetch_count + 32'd1;
      if (state != IDLE && !redir && !issue) stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam int AW = 24;
  localparam int IW = 36;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
  instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) wbus ();

`ifdef IFETCH_STATS_EN
  logic [31:0] fc, sc, wfc, wsc;
`endif

  instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(24'h000000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef IFETCH_STATS_EN
    , .fetch_count(fc), .stall_count(sc)
`endif
  );

  // Second instance checks PC wrap from all-ones to zero.
  instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(24'hFFFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .bus(wbus)
`ifdef IFETCH_STATS_EN
    , .fetch_count(wfc), .stall_count(wsc)
`endif
  );

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      24'd0:   return 36'h011000010;
      24'd1:   return 36'h012000020;
      24'd2:   return 36'h052210000;
      default: return {12'hC3A, a};
    endcase
  endfunction

  // Synchronous instruction memories.
  always @(posedge clk) bus.imem_data  <= mem_word(bus.imem_addr);
  always @(posedge clk) wbus.imem_data <= mem_word(wbus.imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [AW-1:0] pc);
    check({tag, ".valid"}, 64'(bus.instr_valid), 64'd1);
    check({tag, ".pc"},    64'(bus.instr_pc),    64'(pc));
    check({tag, ".word"},  64'(bus.instr_word),  64'(mem_word(pc)));
  endtask

  initial begin
    reset = 1'b1;
    bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    wbus.instr_ready = 1'b1; wbus.redirect_valid = 1'b0; wbus.redirect_target = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst.valid", 64'(bus.instr_valid), 64'd0);
    check("rst.pc",    64'(bus.instr_pc),    64'd0);
    check("rst.word",  64'(bus.instr_word),  64'd0);
    check("rst.addr",  64'(bus.imem_addr),   64'd0);
    check("rst.rnw",   64'(bus.imem_read_not_write), 64'd1);
    check("rst.waddr", 64'(wbus.imem_addr),  64'hFFFFFE);

    // cycle 0: reset released, IDLE
    adv(); reset = 1'b0; bus.instr_ready = 1'b1; #1;
    check("c0.valid", 64'(bus.instr_valid), 64'd0);
    adv(); #1; check("c1.valid", 64'(bus.instr_valid), 64'd0);
    check("c1.addr", 64'(bus.imem_addr), 64'd0);
    adv(); #1; check("c2.valid", 64'(bus.instr_valid), 64'd0);
    adv(); #1;
    check("c3.pc",   64'(bus.instr_pc),   64'd0);
    check("c3.word", 64'(bus.instr_word), 64'h011000010);
    check("c3.valid", 64'(bus.instr_valid), 64'd1);
    check("w3.pc",   64'(wbus.instr_pc),  64'hFFFFFE);
    check("w3.word", 64'(wbus.instr_word), 64'hC3AFFFFFE);
    adv(); #1;
    check("c4.pc",   64'(bus.instr_pc),   64'd1);
    check("c4.word", 64'(bus.instr_word), 64'h012000020);
    check("w4.pc",   64'(wbus.instr_pc),  64'hFFFFFF);
    adv(); #1;
    check("c5.pc",   64'(bus.instr_pc),   64'd2);
    check("c5.word", 64'(bus.instr_word), 64'h052210000);
    check("w5.pc",   64'(wbus.instr_pc),  64'h000000);
    check("w5.word", 64'(wbus.instr_word), 64'h011000010);

    // cycles 6..15: backpressure, head holds PC 3, no new issue (addr stuck at 4)
    for (int c = 6; c < 16; c++) begin
      adv(); bus.instr_ready = 1'b0; #1;
      chk_head("bp", 24'd3);
      check("bp.addr", 64'(bus.imem_addr), 64'd4);
    end

    // cycles 16..19: drain resumes in order, issue restarts on the first pop
    adv(); bus.instr_ready = 1'b1; #1;
    check("c16.addr", 64'(bus.imem_addr), 64'd5);
    chk_head("c16", 24'd3);
    for (int c = 17; c < 20; c++) begin
      adv(); #1;
      chk_head("drain", AW'(c - 13));
    end

    // cycle 20: redirect together with the handshake of PC 7
    adv(); bus.redirect_valid = 1'b1; bus.redirect_target = 24'h000005; #1;
    chk_head("c20", 24'd7);
    adv(); bus.redirect_valid = 1'b0; #1;
    check("c21.valid", 64'(bus.instr_valid), 64'd0);
    check("c21.addr",  64'(bus.imem_addr),   64'd5);
    adv(); #1;
    check("c22.valid", 64'(bus.instr_valid), 64'd0);
    check("c22.addr",  64'(bus.imem_addr),   64'd6);
    adv(); #1; chk_head("c23", 24'd5);
    adv(); #1; chk_head("c24", 24'd6);

    // cycles 25..29: fill queue with 7,8 under backpressure, then redirect
    adv(); bus.instr_ready = 1'b0; #1; chk_head("c25", 24'd7);
    adv(); bus.redirect_valid = 1'b1; bus.redirect_target = 24'h000040; #1;
    chk_head("c26", 24'd7);
    check("c26.addr", 64'(bus.imem_addr), 64'd8);
    adv(); bus.redirect_valid = 1'b0; #1;
    check("c27.valid", 64'(bus.instr_valid), 64'd0);
    check("c27.addr",  64'(bus.imem_addr),   64'h40);
    adv(); #1;
    check("c28.valid", 64'(bus.instr_valid), 64'd0);
    check("c28.addr",  64'(bus.imem_addr),   64'h41);
    adv(); #1;
    chk_head("c29", 24'h40);
    check("c29.addr", 64'(bus.imem_addr), 64'h41);

    // mid-cycle asynchronous reset with one entry queued and one read in flight
    #2; reset = 1'b1; #1;
    check("ar.valid", 64'(bus.instr_valid), 64'd0);
    check("ar.pc",    64'(bus.instr_pc),    64'd0);
    check("ar.word",  64'(bus.instr_word),  64'd0);
    check("ar.addr",  64'(bus.imem_addr),   64'd0);
    check("ar.rnw",   64'(bus.imem_read_not_write), 64'd1);
`ifdef IFETCH_STATS_EN
    check("ar.fc", 64'(fc), 64'd0);
    check("ar.sc", 64'(sc), 64'd0);
`endif
    adv(); reset = 1'b0; bus.instr_ready = 1'b1; #1;
    check("r0.valid", 64'(bus.instr_valid), 64'd0);
    adv(); #1; check("r1.addr", 64'(bus.imem_addr), 64'd0);
    adv(); #1; check("r2.valid", 64'(bus.instr_valid), 64'd0);
    adv(); #1;
    check("r3.pc",   64'(bus.instr_pc),   64'd0);
    check("r3.word", 64'(bus.instr_word), 64'h011000010);
    adv(); #1;
    check("r4.pc",   64'(bus.instr_pc),   64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
